// File: rtl/rstseq.sv
//------------------------------------------------------------------------------
// Module      : rstseq
// Description : Reset sequencer. Holds DOMAINCOUNT reset domains in reset for
//               2^CNTRBITSZ cycles, then releases them in index order spaced
//               STAGGER cycles apart. Decodes software cold/warm/power-off
//               requests and per-domain hardware requests; kept domains
//               survive warm and hardware resets.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rstseq #(
  parameter int DOMAINCOUNT = 3,
  parameter int CNTRBITSZ   = 4,
  parameter int STAGGER     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   swrst0_i,
  input  logic                   swrst1_i,
  input  logic [DOMAINCOUNT-1:0] hwrst_i,
  input  logic [DOMAINCOUNT-1:0] keep_i,
  output logic [DOMAINCOUNT-1:0] rst_o,
  output logic                   gsr_o,
  output logic                   pwroff_o,
  output logic                   busy_o
);

  localparam int c_stag_w = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int c_idx_w  = (DOMAINCOUNT > 1) ? $clog2(DOMAINCOUNT) : 1;
  localparam logic [c_stag_w-1:0] c_stag_load = c_stag_w'(STAGGER - 1);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_RUN     = 3'd2,
    ST_COLD    = 3'd3,
    ST_OFF     = 3'd4
  } state_t;

  state_t                 r_state, w_state_nx;
  logic [CNTRBITSZ-1:0]   r_cntr, w_cntr_nx;
  logic [c_stag_w-1:0]    r_stag, w_stag_nx;
  logic [c_idx_w-1:0]     r_idx, w_idx_nx;
  logic [DOMAINCOUNT-1:0] r_rst, w_rst_nx;
  logic                   r_gsr, w_gsr_nx;
  logic                   r_pwroff, w_pwroff_nx;
  logic                   r_busy, w_busy_nx;

  logic w_req_pwroff, w_req_cold, w_req_warm, w_req_hw;

  // Decode the two-wire software reset encoding and the hardware requests.
  always_comb begin
    w_req_pwroff = swrst0_i & ~swrst1_i;
    w_req_cold   = swrst0_i & swrst1_i;
    w_req_warm   = ~swrst0_i & swrst1_i;
    w_req_hw     = |hwrst_i;
  end

  // Next-state logic: sequencing first, then requests override it.
  always_comb begin
    w_state_nx  = r_state;
    w_cntr_nx   = r_cntr;
    w_stag_nx   = r_stag;
    w_idx_nx    = r_idx;
    w_rst_nx    = r_rst;
    w_gsr_nx    = 1'b0;
    w_pwroff_nx = 1'b0;

    case (r_state)
      ST_HOLD: begin
        if (r_cntr != '0) begin
          w_cntr_nx = r_cntr - CNTRBITSZ'(1);
        end else begin
          w_rst_nx[0] = 1'b0;
          w_idx_nx    = '0;
          w_stag_nx   = c_stag_load;
          w_state_nx  = (DOMAINCOUNT == 1) ? ST_RUN : ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (r_stag != '0) begin
          w_stag_nx = r_stag - c_stag_w'(1);
        end else begin
          // Clearing a bit that a kept domain already has at 0 is harmless.
          for (int k = 0; k < DOMAINCOUNT; k++) begin
            if (k == int'(r_idx) + 1) w_rst_nx[k] = 1'b0;
          end
          w_idx_nx  = r_idx + c_idx_w'(1);
          w_stag_nx = c_stag_load;
          if (int'(r_idx) + 1 == DOMAINCOUNT - 1) w_state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
      end
      ST_COLD: begin
        // Cold reset ignores the keep mask: every domain goes back to reset.
        w_cntr_nx  = '1;
        w_rst_nx   = '1;
        w_idx_nx   = '0;
        w_state_nx = ST_HOLD;
      end
      ST_OFF: begin
        // Only the asynchronous reset leaves power-off.
        w_pwroff_nx = 1'b1;
        w_rst_nx    = '1;
      end
      default: begin
        w_state_nx = ST_HOLD;
        w_cntr_nx  = '1;
        w_rst_nx   = '1;
      end
    endcase

    if ((r_state == ST_HOLD) || (r_state == ST_RELEASE) || (r_state == ST_RUN)) begin
      if (w_req_pwroff) begin
        w_rst_nx    = '1;
        w_pwroff_nx = 1'b1;
        w_state_nx  = ST_OFF;
      end else if (w_req_cold) begin
        w_gsr_nx   = 1'b1;
        w_rst_nx   = '1;
        w_state_nx = ST_COLD;
      end else if (w_req_warm || w_req_hw) begin
        // A level request keeps reloading the hold counter until it drops.
        w_rst_nx   = r_rst | ~keep_i;
        w_cntr_nx  = '1;
        w_idx_nx   = '0;
        w_state_nx = ST_HOLD;
      end
    end

    w_busy_nx = (w_state_nx != ST_RUN);
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_HOLD;
      r_cntr   <= '1;
      r_stag   <= '0;
      r_idx    <= '0;
      r_rst    <= '1;
      r_gsr    <= 1'b0;
      r_pwroff <= 1'b0;
      r_busy   <= 1'b1;
    end else begin
      r_state  <= w_state_nx;
      r_cntr   <= w_cntr_nx;
      r_stag   <= w_stag_nx;
      r_idx    <= w_idx_nx;
      r_rst    <= w_rst_nx;
      r_gsr    <= w_gsr_nx;
      r_pwroff <= w_pwroff_nx;
      r_busy   <= w_busy_nx;
    end
  end

  assign rst_o    = r_rst;
  assign gsr_o    = r_gsr;
  assign pwroff_o = r_pwroff;
  assign busy_o   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rstseq.sv
//------------------------------------------------------------------------------
// Module      : tb_rstseq
// Description : Self-checking bench for rstseq. A schedule-based model tracks
//               the edge at which the first domain is due for release and
//               derives every domain's release edge arithmetically from it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rstseq;

  localparam int N    = 3;
  localparam int CB   = 4;
  localparam int ST   = 2;
  localparam int HOLD = 1 << CB;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         swrst0_i = 1'b0;
  logic         swrst1_i = 1'b0;
  logic [N-1:0] hwrst_i = '0;
  logic [N-1:0] keep_i = '0;
  logic [N-1:0] rst_o;
  logic         gsr_o, pwroff_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int           m_e;
  int           m_t0;
  bit           m_off, m_coldp;
  logic [N-1:0] m_rst;
  logic         m_gsr, m_pwr, m_busy;

  rstseq #(.DOMAINCOUNT(N), .CNTRBITSZ(CB), .STAGGER(ST)) dut (
    .clk_i(clk), .rst_i(rst_i), .swrst0_i(swrst0_i), .swrst1_i(swrst1_i),
    .hwrst_i(hwrst_i), .keep_i(keep_i), .rst_o(rst_o), .gsr_o(gsr_o),
    .pwroff_o(pwroff_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: run still active at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_e = 0; m_t0 = HOLD; m_off = 0; m_coldp = 0;
    m_rst = '1; m_gsr = 0; m_pwr = 0; m_busy = 1;
  endtask

  // One clock edge: the model consumes the inputs that were stable at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_i) begin
      model_reset();
    end else begin
      m_e++;
      m_gsr = 0;
      if (m_off) begin
      end else if (m_coldp) begin
        m_coldp = 0; m_rst = '1; m_t0 = m_e + HOLD;
      end else if (swrst0_i && !swrst1_i) begin
        m_off = 1; m_rst = '1; m_pwr = 1;
      end else if (swrst0_i && swrst1_i) begin
        m_gsr = 1; m_rst = '1; m_coldp = 1;
      end else if (swrst1_i || (hwrst_i != 0)) begin
        m_rst = m_rst | ~keep_i; m_t0 = m_e + HOLD;
      end else begin
        for (int k = 0; k < N; k++) if (m_e == m_t0 + k * ST) m_rst[k] = 1'b0;
      end
      m_busy = m_off || m_coldp || (m_e < m_t0 + (N - 1) * ST);
    end
    #1;
  endtask

  task automatic clear_inputs();
    swrst0_i = 0; swrst1_i = 0; hwrst_i = '0; keep_i = '0;
  endtask

  task automatic restart();
    clear_inputs();
    rst_i = 1; tick(); tick();
    rst_i = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1; tick(); tick();
    n_checks++;
    if ({rst_o, gsr_o, pwroff_o, busy_o} !== 6'b111_0_0_1) begin
      n_fail++;
      $display("FAIL reset_state: got rst=%b gsr=%b pwroff=%b busy=%b, required 111 0 0 1",
               rst_o, gsr_o, pwroff_o, busy_o);
    end
  endtask

  task automatic test_powerup();
    logic [N-1:0] exp;
    restart();
    for (int i = 0; i < 24; i++) begin
      tick();
      exp = {(m_e < HOLD + 2 * ST), (m_e < HOLD + ST), (m_e < HOLD)};
      n_checks++;
      if (rst_o !== exp || busy_o !== (m_e < HOLD + 2 * ST) || gsr_o !== 0 || pwroff_o !== 0) begin
        n_fail++;
        $display("FAIL powerup edge %0d: got rst=%b busy=%b gsr=%b pwroff=%b, required rst=%b busy=%b 0 0",
                 m_e, rst_o, busy_o, gsr_o, pwroff_o, exp, (m_e < HOLD + 2 * ST));
      end
    end
  endtask

  task automatic test_warm_keep();
    int n;
    keep_i = 3'b100; swrst1_i = 1;
    tick();
    n = m_e;
    n_checks++;
    if (rst_o !== 3'b011 || gsr_o !== 0) begin
      n_fail++;
      $display("FAIL warm_keep_assert: got rst=%b gsr=%b, required 011 0", rst_o, gsr_o);
    end
    swrst1_i = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      n_checks++;
      if ({rst_o, gsr_o, pwroff_o, busy_o} !== {m_rst, m_gsr, m_pwr, m_busy}) begin
        n_fail++;
        $display("FAIL warm_keep edge %0d: got %b %b %b %b, required %b %b %b %b", m_e,
                 rst_o, gsr_o, pwroff_o, busy_o, m_rst, m_gsr, m_pwr, m_busy);
      end
      if (m_e == n + HOLD || m_e == n + HOLD + ST) begin
        n_checks++;
        if (rst_o !== ((m_e == n + HOLD) ? 3'b010 : 3'b000)) begin
          n_fail++;
          $display("FAIL warm_keep_release edge %0d: got rst=%b", m_e, rst_o);
        end
      end
    end
    keep_i = '0;
  endtask

  task automatic test_hw_mid_release();
    restart();
    while (m_e < 16) tick();
    hwrst_i = 3'b001;
    tick();
    n_checks++;
    if (rst_o !== 3'b111) begin
      n_fail++;
      $display("FAIL hw_mid_release edge %0d: got rst=%b, required 111", m_e, rst_o);
    end
    hwrst_i = '0;
    while (m_e < 38) begin
      tick();
      if (m_e == 32 || m_e == 33 || m_e == 35 || m_e == 37) begin
        n_checks++;
        if (rst_o !== ((m_e == 32) ? 3'b111 : (m_e == 33) ? 3'b110 : (m_e == 35) ? 3'b100 : 3'b000)) begin
          n_fail++;
          $display("FAIL hw_release edge %0d: got rst=%b", m_e, rst_o);
        end
      end
    end
  endtask

  task automatic test_cold();
    int n, gsr_cnt;
    keep_i = 3'b111; swrst0_i = 1; swrst1_i = 1;
    tick();
    n = m_e;
    gsr_cnt = int'(gsr_o);
    n_checks++;
    if (gsr_o !== 1 || rst_o !== 3'b111) begin
      n_fail++;
      $display("FAIL cold_assert: got gsr=%b rst=%b, required 1 111", gsr_o, rst_o);
    end
    swrst0_i = 0; swrst1_i = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      gsr_cnt += int'(gsr_o);
      n_checks++;
      if ({rst_o, gsr_o, pwroff_o, busy_o} !== {m_rst, m_gsr, m_pwr, m_busy}) begin
        n_fail++;
        $display("FAIL cold_seq edge %0d: got %b %b %b %b, required %b %b %b %b", m_e,
                 rst_o, gsr_o, pwroff_o, busy_o, m_rst, m_gsr, m_pwr, m_busy);
      end
    end
    n_checks++;
    if (gsr_cnt != 1) begin
      n_fail++;
      $display("FAIL cold_gsr_width: got %0d cycles, required 1", gsr_cnt);
    end
    n_checks++;
    if (m_e != n + 24 || rst_o !== 3'b000) begin
      n_fail++;
      $display("FAIL cold_release_end: got rst=%b, required 000", rst_o);
    end
    keep_i = '0;
  endtask

  task automatic test_random();
    int r;
    restart();
    for (int i = 0; i < 1500; i++) begin
      tick();
      n_checks++;
      if ({rst_o, gsr_o, pwroff_o, busy_o} !== {m_rst, m_gsr, m_pwr, m_busy}) begin
        n_fail++;
        $display("FAIL random edge %0d: got %b %b %b %b, required %b %b %b %b", m_e,
                 rst_o, gsr_o, pwroff_o, busy_o, m_rst, m_gsr, m_pwr, m_busy);
      end
      r = $urandom_range(0, 99);
      swrst0_i = (r < 2);
      swrst1_i = (r < 2) || (r >= 2 && r < 6);
      hwrst_i  = ($urandom_range(0, 99) < 3) ? N'($urandom_range(1, (1 << N) - 1)) : '0;
      if ($urandom_range(0, 19) == 0) keep_i = N'($urandom);
    end
    clear_inputs();
  endtask

  task automatic test_poweroff();
    int r;
    restart();
    repeat (22) tick();
    swrst0_i = 1; swrst1_i = 0;
    tick();
    n_checks++;
    if (pwroff_o !== 1 || rst_o !== 3'b111) begin
      n_fail++;
      $display("FAIL pwroff_assert: got pwroff=%b rst=%b, required 1 111", pwroff_o, rst_o);
    end
    for (int i = 0; i < 100; i++) begin
      r = $urandom_range(0, 2);
      swrst0_i = (r == 1);
      swrst1_i = (r != 2);
      hwrst_i  = N'($urandom);
      tick();
      n_checks++;
      if ({rst_o, gsr_o, pwroff_o, busy_o} !== 6'b111_0_1_1) begin
        n_fail++;
        $display("FAIL pwroff_hold edge %0d: got %b %b %b %b, required 111 0 1 1", m_e,
                 rst_o, gsr_o, pwroff_o, busy_o);
      end
    end
    clear_inputs();
    #2;
    rst_i = 1;
    #1;
    model_reset();
    n_checks++;
    if (pwroff_o !== 0 || rst_o !== 3'b111 || busy_o !== 1) begin
      n_fail++;
      $display("FAIL pwroff_async_clear: got pwroff=%b rst=%b busy=%b, required 0 111 1",
               pwroff_o, rst_o, busy_o);
    end
    tick();
    rst_i = 0;
  endtask

  task automatic test_priority();
    restart();
    repeat (5) tick();
    swrst0_i = 1; swrst1_i = 1; hwrst_i = 3'b111;
    tick();
    n_checks++;
    if (gsr_o !== 1 || pwroff_o !== 0 || rst_o !== 3'b111) begin
      n_fail++;
      $display("FAIL prio_cold_over_hw: got gsr=%b pwroff=%b rst=%b, required 1 0 111",
               gsr_o, pwroff_o, rst_o);
    end
    clear_inputs();
    tick();
    swrst0_i = 1; swrst1_i = 0; hwrst_i = 3'b111;
    tick();
    n_checks++;
    if (pwroff_o !== 1 || gsr_o !== 0 || rst_o !== 3'b111) begin
      n_fail++;
      $display("FAIL prio_pwroff: got pwroff=%b gsr=%b rst=%b, required 1 0 111",
               pwroff_o, gsr_o, rst_o);
    end
    swrst1_i = 1;
    tick();
    n_checks++;
    if (pwroff_o !== 1 || gsr_o !== 0 || busy_o !== 1) begin
      n_fail++;
      $display("FAIL prio_off_sticky: got pwroff=%b gsr=%b busy=%b, required 1 0 1",
               pwroff_o, gsr_o, busy_o);
    end
    clear_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_powerup();
    test_warm_keep();
    test_hw_mid_release();
    repeat (6) tick();
    test_cold();
    test_random();
    test_poweroff();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rstseq.md
# rstseq

Parametrised reset sequencer replacing the hand-built reset counters in board top levels. It holds a configurable number of reset domains in reset for a programmable count after power-up or a request, then releases them one by one in index order, staggered by a fixed gap. It decodes the devtbl software reset encoding (cold, warm, power-off) and per-domain hardware reset requests such as multipu `rst_o`. A keep mask lets selected domains, e.g. the uart, survive warm resets.

## Interface
- `DOMAINCOUNT`, 3: number of reset domains (≥1); domain 0 is released first.
- `CNTRBITSZ`, 4: hold counter width; hold lasts 2^CNTRBITSZ cycles.
- `STAGGER`, 2: cycles between consecutive domain releases (≥1).
- `clk_i`  in  1: single clock for all logic.
- `rst_i`  in  1: reset, asynchronous, active-high; board ties it to `!pll_locked || rst_p`.
- `swrst0_i`  in  1: devtbl `rst0_o`.
- `swrst1_i`  in  1: devtbl `rst1_o`.
- `hwrst_i`  in  DOMAINCOUNT: per-domain hardware reset request, level.
- `keep_i`  in  DOMAINCOUNT: bit set means that domain is exempt from warm and hardware resets.
- `rst_o`  out  DOMAINCOUNT: per-domain reset, active-high, registered.
- `gsr_o`  out  1: one-cycle cold-reset pulse, drives `STARTUP_SPARTAN6` GSR.
- `pwroff_o`  out  1: power-off state indicator.
- `busy_o`  out  1: high whenever the state is not RUN.

## Operation
- Request decode, evaluated in fixed priority order:
  - pwroff = `swrst0_i & !swrst1_i`
  - cold = `swrst0_i & swrst1_i`
  - warm = `!swrst0_i & swrst1_i`
  - hw = `|hwrst_i`
- Registers:
  - state ∈ {HOLD, RELEASE, RUN, COLD, OFF}
  - `cntr` [CNTRBITSZ]
  - `stag` [clog2(STAGGER) min 1]
  - `idx` [clog2(DOMAINCOUNT) min 1]
- `rst_i` high (async): state=HOLD, `cntr`=all ones, `rst_o`=all ones, `gsr_o`=0, `pwroff_o`=0, `busy_o`=1, `idx`=0, `stag`=0.
- HOLD:
  - If `cntr`≠0, decrement `cntr`.
  - If `cntr`=0: clear `rst_o[0]`, set `idx`=0, load `stag`=STAGGER-1, go to RELEASE. If DOMAINCOUNT=1, go straight to RUN.
- RELEASE:
  - If `stag`≠0, decrement `stag`.
  - Otherwise clear `rst_o[idx+1]`, increment `idx`, reload `stag`. If `idx+1`=DOMAINCOUNT-1, go to RUN.
- RUN: all `rst_o` stay 0 until a request arrives.
- Request handling in HOLD, RELEASE and RUN; the highest-priority active request wins:
  - pwroff: set `rst_o`=all ones, `pwroff_o`=1, go to OFF.
  - cold: set `gsr_o`=1, `rst_o`=all ones, go to COLD.
  - warm or hw: set `rst_o[k]`=1 for every k with `keep_i[k]`=0. Kept bits hold their current value. Reload `cntr`=all ones, set `idx`=0, go to HOLD.
- Requests are levels. A warm or hw request held high keeps reloading `cntr`, so the domains stay in reset until the request drops.
- A kept domain whose bit is already 0 is unaffected when the release step reaches its index; clearing an already-clear bit is a no-op.
- COLD:
  - Lasts one cycle. `gsr_o` returns to 0 and `cntr` is reloaded.
  - Go to HOLD with every domain in reset, kept domains included; `keep_i` is ignored for cold.
- OFF:
  - `pwroff_o`=1 and `rst_o`=all ones.
  - All requests are ignored. Only `rst_i` leaves OFF.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Release schedule: with `rst_i` falling before edge 1, `rst_o[k]` falls at edge 2^CNTRBITSZ + k·STAGGER.
  - Defaults: `rst_o[0]` at edge 16, `rst_o[1]` at 18, `rst_o[2]` at 20.
  - `busy_o` falls on the same edge as the last domain's release.
- Request reaction: a request sampled at edge n changes `rst_o`, `gsr_o` and `pwroff_o` at edge n.
  - After a warm request ends at edge n, the first release occurs at edge n + 2^CNTRBITSZ.
- Simultaneous warm and hw are one event.
- A warm request arriving mid-RELEASE re-asserts domains that were already released (unless kept) and restarts from domain 0.
- Simultaneous pwroff and cold: pwroff wins.
- `rst_i` asserted mid-sequence returns every register to its reset value immediately, regardless of clock.

## Test plan
- **Power-up:** DOMAINCOUNT=3, CNTRBITSZ=4, STAGGER=2; deassert `rst_i`.
  - Required: `rst_o` = 111 through edge 15, 110 at edge 16, 100 at edge 18, 000 at edge 20.
  - `busy_o` 0 from edge 20.
- **Warm reset with keep:** in RUN, `keep_i`=100, pulse `swrst1_i` for 1 cycle.
  - Required: `rst_o`=011 on the sampling edge; bit 2 stays 0.
  - Bits 0 and 1 re-release 16 and 18 cycles after the request drops; `gsr_o` stays 0.
- **Hardware request mid-release:** assert `hwrst_i[0]` for 1 cycle at edge 17, when `rst_o`=110.
  - Required: `rst_o`=111 at edge 17.
  - Releases resume at edges 33, 35, 37.
- **Cold reset:** in RUN, set `swrst0_i`=`swrst1_i`=1 for 1 cycle with `keep_i`=111.
  - Required: `gsr_o`=1 for exactly one cycle and `rst_o`=111.
  - Full staggered release follows.
- **Power-off:** set `swrst0_i`=1, `swrst1_i`=0.
  - Required: `pwroff_o`=1, `rst_o`=111.
  - Subsequent warm, cold and hw requests are ignored for 100 cycles.
  - Asserting `rst_i` clears `pwroff_o` asynchronously, before the next clock edge.
- **Priority:** assert pwroff, cold and `hwrst_i`=111 in the same cycle.
  - Required: state OFF, `gsr_o` stays 0.
